// File: rtl/risc_pkg.sv
// Shared types, opcodes and IR field helpers for the simple RISC control path.
// Memory instructions are built only when CTRL_MEMOPS_EN is defined.
package risc_pkg;

  typedef enum logic [4:0] {
    S_FETCH,
    S_LOADIR,
    S_DECODE,
    S_WIMM,
    S_IDLE,
    S_RDN,
    S_RDM,
    S_PASS,
    S_EXE,
    S_WB,
    S_ADDR,
    S_MEMA,
    S_MEMR,
    S_LDAR,
    S_RDD,
    S_MEMW,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_MOVI,
    C_MOVR,
    C_ADD,
    C_AND,
    C_CMP,
    C_MVN,
    C_LDR,
    C_STR,
    C_HALT
  } iclass_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MEM  = 2'b00;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] WB_C   = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_RAM = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

  function automatic logic [2:0] ir_opc(input logic [15:0] ir);
    return ir[15:13];
  endfunction

  function automatic logic [1:0] ir_op(input logic [15:0] ir);
    return ir[12:11];
  endfunction

  function automatic logic [2:0] ir_rn(input logic [15:0] ir);
    return ir[10:8];
  endfunction

  function automatic logic [2:0] ir_rd(input logic [15:0] ir);
    return ir[7:5];
  endfunction

  function automatic logic [1:0] ir_sh(input logic [15:0] ir);
    return ir[4:3];
  endfunction

  function automatic logic [2:0] ir_rm(input logic [15:0] ir);
    return ir[2:0];
  endfunction

endpackage

// File: rtl/risc_ctrl_fsm_decode.sv
// IR to instruction-class decode plus immediate sign extension.
// LDR/STR classes are recognised only when CTRL_MEMOPS_EN is defined.
module risc_decode
  import risc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output iclass_t           iclass,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = ir_opc(ir);
  assign op  = ir_op(ir);

  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

  always_comb begin
    iclass = C_HALT;
    unique case (1'b1)
      (opc == OPC_MOV && op == OP_MOVI): iclass = C_MOVI;
      (opc == OPC_MOV && op == OP_MOVR): iclass = C_MOVR;
      (opc == OPC_ALU && op == OP_ADD):  iclass = C_ADD;
      (opc == OPC_ALU && op == OP_CMP):  iclass = C_CMP;
      (opc == OPC_ALU && op == OP_AND):  iclass = C_AND;
      (opc == OPC_ALU && op == OP_MVN):  iclass = C_MVN;
`ifdef CTRL_MEMOPS_EN
      (opc == OPC_LDR && op == OP_MEM):  iclass = C_LDR;
      (opc == OPC_STR && op == OP_MEM):  iclass = C_STR;
`endif
      default:                           iclass = C_HALT;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle Moore control FSM for the 16-bit simple RISC datapath.
// Define CTRL_MEMOPS_EN to add LDR/STR and the data address register.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   start_pc,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] dp_c,
  output logic [PC_W-1:0]   ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [2:0]        reg_r_addr,
  output logic [2:0]        reg_w_addr,
  output logic              reg_w_en,
  output logic [1:0]        wb_sel,
  output logic              en_A,
  output logic              en_B,
  output logic              en_C,
  output logic              en_status,
  output logic              sel_A,
  output logic              sel_B,
  output logic [1:0]        shift_op,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  iclass_t           iclass;
  logic [2:0]        rn, rd, rm;
  logic [1:0]        sh;
`ifdef CTRL_MEMOPS_EN
  logic [PC_W-1:0]   dar_q, dar_d;
`endif

  risc_decode #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir_q),
    .iclass (iclass),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  assign rn        = ir_rn(ir_q);
  assign rd        = ir_rd(ir_q);
  assign rm        = ir_rm(ir_q);
  assign sh        = ir_sh(ir_q);
  assign pc        = pc_q;
  assign ram_wdata = dp_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= start_pc;
      ir_q    <= '0;
`ifdef CTRL_MEMOPS_EN
      dar_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef CTRL_MEMOPS_EN
      dar_q   <= dar_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
`ifdef CTRL_MEMOPS_EN
    dar_d      = dar_q;
`endif
    ram_addr   = '0;
    ram_wr     = 1'b0;
    reg_r_addr = 3'd0;
    reg_w_addr = 3'd0;
    reg_w_en   = 1'b0;
    wb_sel     = WB_C;
    en_A       = 1'b0;
    en_B       = 1'b0;
    en_C       = 1'b0;
    en_status  = 1'b0;
    sel_A      = 1'b0;
    sel_B      = 1'b0;
    shift_op   = 2'b00;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ram_addr = pc_q;
        state_d  = S_LOADIR;
      end
      S_LOADIR: begin
        ir_d    = ram_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        pc_d = pc_q + PC_W'(1);
        unique case (iclass)
          C_MOVI:               state_d = S_WIMM;
          C_MOVR, C_MVN:        state_d = S_RDM;
          C_ADD, C_AND, C_CMP:  state_d = S_RDN;
`ifdef CTRL_MEMOPS_EN
          C_LDR, C_STR:         state_d = S_RDN;
`endif
          default:              state_d = S_HALT;
        endcase
      end
      S_WIMM: begin
        wb_sel     = WB_IMM;
        reg_w_addr = rn;
        reg_w_en   = 1'b1;
        state_d    = S_IDLE;
      end
      S_IDLE: state_d = S_FETCH;
      S_RDN: begin
        reg_r_addr = rn;
        en_A       = 1'b1;
        state_d    = (iclass == C_LDR || iclass == C_STR) ? S_ADDR : S_RDM;
      end
      S_RDM: begin
        reg_r_addr = rm;
        en_B       = 1'b1;
        shift_op   = sh;
        state_d    = (iclass == C_MOVR) ? S_PASS : S_EXE;
      end
      S_PASS: begin
        sel_A    = 1'b1;
        en_C     = 1'b1;
        // store data passes through unshifted; IR[4:3] there is offset
        shift_op = (iclass == C_MOVR) ? sh : 2'b00;
        state_d  = (iclass == C_STR) ? S_MEMW : S_WB;
      end
      S_EXE: begin
        shift_op = sh;
        unique case (iclass)
          C_CMP:   alu_op = ALU_SUB;
          C_AND:   alu_op = ALU_AND;
          C_MVN:   alu_op = ALU_NOTB;
          default: alu_op = ALU_ADD;
        endcase
        if (iclass == C_CMP) begin
          en_status = 1'b1;
          state_d   = S_FETCH;
        end else begin
          en_C    = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        wb_sel     = (iclass == C_LDR) ? WB_RAM : WB_C;
        reg_w_addr = rd;
        reg_w_en   = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef CTRL_MEMOPS_EN
      S_ADDR: begin
        sel_B   = 1'b1;
        en_C    = 1'b1;
        state_d = (iclass == C_LDR) ? S_MEMA : S_LDAR;
      end
      S_MEMA: begin
        dar_d   = dp_c[PC_W-1:0];
        state_d = S_MEMR;
      end
      S_MEMR: begin
        ram_addr = dar_q;
        state_d  = S_WB;
      end
      S_LDAR: begin
        dar_d   = dp_c[PC_W-1:0];
        state_d = S_RDD;
      end
      S_RDD: begin
        reg_r_addr = rd;
        en_B       = 1'b1;
        state_d    = S_PASS;
      end
      S_MEMW: begin
        ram_addr = dar_q;
        ram_wr   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      S_HALT: halted = 1'b1;
      default: state_d = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Bench for risc_ctrl_fsm: RAM + datapath environment, ISA-level reference.
// Build with CTRL_MEMOPS_EN to exercise LDR/STR.
`timescale 1ns/1ps
module tb_risc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  start_pc = 8'h00;
  logic [15:0] ram_rdata;
  logic [15:0] dp_c;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [15:0] ram_wdata;
  logic [2:0]  reg_r_addr, reg_w_addr;
  logic        reg_w_en;
  logic [1:0]  wb_sel;
  logic        en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic [1:0]  shift_op, alu_op;
  logic [15:0] sximm8, sximm5;
  logic [7:0]  pc;
  logic        halted;

  always #5 clk = ~clk;

  risc_ctrl_fsm #(.PC_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_pc(start_pc),
    .ram_rdata(ram_rdata), .dp_c(dp_c),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .reg_r_addr(reg_r_addr), .reg_w_addr(reg_w_addr),
    .reg_w_en(reg_w_en), .wb_sel(wb_sel),
    .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
    .sel_A(sel_A), .sel_B(sel_B), .shift_op(shift_op), .alu_op(alu_op),
    .sximm8(sximm8), .sximm5(sximm5), .pc(pc), .halted(halted)
  );

  logic [15:0] ld_mem [256];
  logic [15:0] mem [256];
  logic [15:0] rf [8];
  logic [15:0] a_q, b_q, c_q;
  logic [15:0] ain, bin, alu, wbd;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd1:    return v << 1;
      2'd2:    return v >> 1;
      2'd3:    return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    ain = sel_A ? 16'h0000 : a_q;
    bin = sel_B ? sximm5 : shf(b_q, shift_op);
    case (alu_op)
      2'd0:    alu = ain + bin;
      2'd1:    alu = ain - bin;
      2'd2:    alu = ain & bin;
      default: alu = ~bin;
    endcase
    case (wb_sel)
      2'd0:    wbd = c_q;
      2'd1:    wbd = sximm8;
      2'd2:    wbd = ram_rdata;
      default: wbd = {8'h00, pc};
    endcase
  end

  assign dp_c = c_q;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (!rst_n) begin
      mem <= ld_mem;
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      a_q <= 16'h0000;
      b_q <= 16'h0000;
      c_q <= 16'h0000;
    end else begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      if (en_A) a_q <= rf[reg_r_addr];
      if (en_B) b_q <= rf[reg_r_addr];
      if (en_C) c_q <= alu;
      if (reg_w_en) rf[reg_w_addr] <= wbd;
    end
  end

  typedef struct packed {
    logic [2:0]  a;
    logic [1:0]  s;
    logic [15:0] d;
  } wr_t;
  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } mw_t;

  wr_t  exp_wr[$], got_wr[$];
  mw_t  exp_mw[$], got_mw[$];
  int   exp_cyc[$], pc_edges[$];
  int   exp_tot, exp_st, n_st, halt_edges;
  logic [7:0] exp_pc;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) ld_mem[i] = 16'h0000;
  endtask

  task automatic ref_run(input logic [7:0] spc);
    logic [15:0] r [8];
    logic [15:0] m [256];
    logic [7:0]  p, ad;
    logic [15:0] ir, bv, res, sx5;
    logic [4:0]  key;
    logic        done;
    int          cyc;
    m = ld_mem;
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    exp_wr.delete(); exp_mw.delete(); exp_cyc.delete();
    p = spc; exp_tot = 0; exp_st = 0; done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      ir  = m[p];
      p   = p + 8'd1;
      key = ir[15:11];
      bv  = shf(r[ir[2:0]], ir[4:3]);
      sx5 = {{11{ir[4]}}, ir[4:0]};
      ad  = 8'(r[ir[10:8]] + sx5);
      cyc = 0;
      case (key)
        5'b11010: begin
          res = {{8{ir[7]}}, ir[7:0]};
          r[ir[10:8]] = res;
          exp_wr.push_back('{ir[10:8], 2'b01, res});
          cyc = 5;
        end
        5'b11000: begin
          r[ir[7:5]] = bv;
          exp_wr.push_back('{ir[7:5], 2'b00, bv});
          cyc = 6;
        end
        5'b10100, 5'b10110: begin
          res = (key == 5'b10100) ? r[ir[10:8]] + bv : r[ir[10:8]] & bv;
          r[ir[7:5]] = res;
          exp_wr.push_back('{ir[7:5], 2'b00, res});
          cyc = 7;
        end
        5'b10101: begin
          exp_st++;
          cyc = 6;
        end
        5'b10111: begin
          r[ir[7:5]] = ~bv;
          exp_wr.push_back('{ir[7:5], 2'b00, ~bv});
          cyc = 6;
        end
`ifdef CTRL_MEMOPS_EN
        5'b01100: begin
          r[ir[7:5]] = m[ad];
          exp_wr.push_back('{ir[7:5], 2'b10, m[ad]});
          cyc = 8;
        end
        5'b10000: begin
          m[ad] = r[ir[7:5]];
          exp_mw.push_back('{ad, r[ir[7:5]]});
          cyc = 9;
        end
`endif
        default: done = 1'b1;
      endcase
      if (done) exp_tot += 3;
      else begin
        exp_tot += cyc;
        exp_cyc.push_back(cyc);
      end
    end
    exp_pc = p;
  endtask

  task automatic reset_dut(input logic [7:0] spc, input string tg);
    start_pc = spc;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tg, ".rst_pc"}, pc, spc);
    chk({tg, ".rst_addr"}, ram_addr, spc);
    chk({tg, ".rst_strb"},
        {reg_w_en, ram_wr, en_A, en_B, en_C, en_status, halted}, 0);
    rst_n = 1'b1;
  endtask

  task automatic observe(input int budget);
    logic [7:0] last_pc;
    got_wr.delete(); got_mw.delete(); pc_edges.delete();
    n_st = 0; halt_edges = 0; last_pc = pc;
    while (halted !== 1'b1 && halt_edges < budget) begin
      if (reg_w_en) got_wr.push_back('{reg_w_addr, wb_sel, wbd});
      if (ram_wr) got_mw.push_back('{ram_addr, ram_wdata});
      if (en_status) n_st++;
      @(posedge clk);
      #1;
      halt_edges++;
      if (pc !== last_pc) begin
        pc_edges.push_back(halt_edges);
        last_pc = pc;
      end
    end
  endtask

  task automatic check_run(input string tg);
    chk({tg, ".halted"}, halted, 1);
    chk({tg, ".edges"}, halt_edges, exp_tot);
    chk({tg, ".pc"}, pc, exp_pc);
    chk({tg, ".nwr"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      chk($sformatf("%s.wr%0d", tg, i), got_wr[i], exp_wr[i]);
    chk({tg, ".ninstr"}, pc_edges.size(), exp_cyc.size() + 1);
    for (int i = 0; i < exp_cyc.size() && i + 1 < pc_edges.size(); i++)
      chk($sformatf("%s.cyc%0d", tg, i), pc_edges[i+1] - pc_edges[i], exp_cyc[i]);
    chk({tg, ".nstatus"}, n_st, exp_st);
    chk({tg, ".nmw"}, got_mw.size(), exp_mw.size());
    for (int i = 0; i < got_mw.size() && i < exp_mw.size(); i++)
      chk($sformatf("%s.mw%0d", tg, i), got_mw[i], exp_mw[i]);
  endtask

  initial begin
    logic [7:0]  spc;
    logic [4:0]  kinds [6];
    logic [4:0]  kd;
    logic [10:0] lo;
    kinds[0] = 5'b11010; kinds[1] = 5'b11000; kinds[2] = 5'b10100;
    kinds[3] = 5'b10110; kinds[4] = 5'b10101; kinds[5] = 5'b10111;

    clear_mem();
    ld_mem[0] = 16'hD04E; ld_mem[1] = 16'hC030;
    ld_mem[2] = 16'hB041; ld_mem[3] = 16'hE000;
    reset_dut(8'h00, "prog");
    observe(200);
    chk("prog.edges21", halt_edges, 21);
    chk("prog.pc04", pc, 8'h04);
    chk("prog.wr0", {got_wr.size() > 0 ? got_wr[0] : wr_t'(0)}, {3'd0, 2'b01, 16'd78});
    ref_run(8'h00);
    check_run("prog");

    clear_mem();
    ld_mem[8'hFE] = 16'hD04E; ld_mem[8'hFF] = 16'hE000;
    reset_dut(8'hFE, "wrap");
    observe(200);
    chk("wrap.pc00", pc, 8'h00);
    ref_run(8'hFE);
    check_run("wrap");

    clear_mem();
    ld_mem[2] = 16'hB041; ld_mem[3] = 16'hE000;
    reset_dut(8'h02, "mid");
    repeat (5) @(posedge clk);
    #1;
    chk("mid.in_exe", {en_C, reg_w_en, alu_op}, {1'b1, 1'b0, 2'b10});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.fetch_addr", ram_addr, 8'h02);
    chk("mid.pc", pc, 8'h02);
    chk("mid.strb", {reg_w_en, en_C, halted}, 0);
    rst_n = 1'b1;
    observe(200);
    ref_run(8'h02);
    check_run("mid");
    chk("mid.pc04", pc, 8'h04);

    clear_mem();
    ld_mem[0] = 16'hF800;
    reset_dut(8'h00, "undef");
    observe(200);
    chk("undef.edges3", halt_edges, 3);
    ref_run(8'h00);
    check_run("undef");

    clear_mem();
    ld_mem[0] = 16'hA801; ld_mem[1] = 16'hE000;
    reset_dut(8'h00, "cmp");
    observe(200);
    chk("cmp.st1", n_st, 1);
    chk("cmp.cyc6", pc_edges.size() > 1 ? pc_edges[1] - pc_edges[0] : 0, 6);
    ref_run(8'h00);
    check_run("cmp");

    clear_mem();
    ld_mem[0] = 16'hD005; ld_mem[1] = 16'hD209;
    ld_mem[2] = 16'h8041; ld_mem[3] = 16'h6061;
    ld_mem[4] = 16'hE000;
    reset_dut(8'h00, "mem");
    observe(200);
    ref_run(8'h00);
    check_run("mem");
`ifdef CTRL_MEMOPS_EN
    chk("mem.str", {got_mw.size() > 0 ? got_mw[0] : mw_t'(0)}, {8'h06, 16'd9});
    chk("mem.ram6", mem[6], 16'd9);
`else
    chk("mem.nowr", got_mw.size(), 0);
`endif

    for (int t = 0; t < 10; t++) begin
      clear_mem();
      spc = 8'($urandom_range(0, 255));
      for (int k = 0; k < 7; k++) begin
        kd = kinds[$urandom_range(0, 5)];
        lo = 11'($urandom);
        ld_mem[8'(spc + 8'(k))] = {kd, lo};
      end
      ld_mem[8'(spc + 8'd7)] = 16'hE000;
      reset_dut(spc, $sformatf("rnd%0d", t));
      observe(300);
      ref_run(spc);
      check_run($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
